// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath (register file, ALU, control).
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // Architectural register 0 is hardwired to zero.
  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: write-through bypass, hardwired zero, else stored value.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Bypass has priority so a same-cycle write is seen by the ALU; index 0 never bypasses.
  always_comb begin
    rdata = stored;
    if (rst_n && we && (waddr != ZERO_IDX) && (waddr == raddr)) begin
      rdata = wdata;
    end else if (raddr == ZERO_IDX) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two bypassed read ports, one write port, raw debug read.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Only registers 1..DEPTH-1 have storage; index 0 is synthesised as a constant.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DATA_W-1:0] view [DEPTH];

  // Storage: async clear, then one write per rising edge; writes to index 0 are dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZERO_IDX)) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (waddr_i == ADDR_W'(i)) begin
          regs[i] <= wdata_i;
        end
      end
    end
  end

  // Full-depth view of architectural state with register 0 tied to zero.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = regs[i];
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port0 (
    .rst_n  (rst_n_i),
    .we     (we_i),
    .waddr  (waddr_i),
    .wdata  (wdata_i),
    .raddr  (raddr0_i),
    .stored (view[raddr0_i]),
    .rdata  (rdata0_o)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .rst_n  (rst_n_i),
    .we     (we_i),
    .waddr  (waddr_i),
    .wdata  (wdata_i),
    .raddr  (raddr1_i),
    .stored (view[raddr1_i]),
    .rdata  (rdata1_o)
  );

  // Debug port shows stored state only, never the in-flight write.
  assign dbg_data_o = view[dbg_addr_i];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic vs. a model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr0;
  logic [4:0]  raddr1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference architectural state; entry 0 is never written.
  logic [31:0] model [32];

  reg_file dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .raddr0_i   (raddr0),
    .raddr1_i   (raddr1),
    .rdata0_o   (rdata0),
    .rdata1_o   (rdata1),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: committed writes on rising edges out of reset; async clear on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (!rst_n) return 32'h0;
    if (we && waddr != 5'd0 && waddr == ra) return wdata;
    return model[ra];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    raddr0 = 5'd3; raddr1 = 5'd3; dbg_addr = 5'd3;

    // Reset held with a pending write: nothing lands, outputs stay zero.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_rdata0", rdata0, 32'h0);
      check("rst_rdata1", rdata1, 32'h0);
      check("rst_dbg3", dbg_data, 32'h0);
    end
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    #1 check("post_rst_dbg3", dbg_data, 32'h0);

    // Basic write then read on both ports.
    write_reg(5'd5, 32'h0000_1234);
    raddr0 = 5'd5; raddr1 = 5'd5; dbg_addr = 5'd5;
    #1;
    check("basic_rdata0", rdata0, 32'h0000_1234);
    check("basic_rdata1", rdata1, 32'h0000_1234);
    check("basic_dbg5", dbg_data, 32'h0000_1234);

    // Zero register: write discarded, never bypassed.
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr0 = 5'd0; dbg_addr = 5'd0;
    #1 check("zero_same_cycle", rdata0, 32'h0);
    @(posedge clk); #1;
    check("zero_after_edge", rdata0, 32'h0);
    check("zero_dbg", dbg_data, 32'h0);
    @(negedge clk);
    we = 1'b0;

    // Bypass: in-flight write visible on read port, debug shows old value until the edge.
    write_reg(5'd7, 32'h11);
    we = 1'b1; waddr = 5'd7; wdata = 32'h22; raddr1 = 5'd7; raddr0 = 5'd7; dbg_addr = 5'd7;
    #1;
    check("bypass_rdata1", rdata1, 32'h22);
    check("bypass_rdata0", rdata0, 32'h22);
    check("bypass_dbg_old", dbg_data, 32'h11);
    @(posedge clk); #1;
    check("bypass_dbg_new", dbg_data, 32'h22);
    @(negedge clk);
    we = 1'b0;

    // Async reset between edges with a write pending.
    write_reg(5'd31, 32'hA5A5_A5A5);
    dbg_addr = 5'd31; raddr0 = 5'd31;
    #1 check("r31_written", dbg_data, 32'hA5A5_A5A5);
    we = 1'b1; waddr = 5'd31; wdata = 32'h1234_5678;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_dbg31", dbg_data, 32'h0);
    check("async_rst_rdata0", rdata0, 32'h0);
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    #1 check("async_rst_write_lost", dbg_data, 32'h0);

    // ALU-facing operands: r1=10, r2=3; differences and sums taken on DUT outputs.
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd3);
    raddr0 = 5'd1; raddr1 = 5'd2;
    #1;
    check("alu_sub", rdata0 - rdata1, 32'd7);
    check("alu_sub_zero", {31'd0, (rdata0 - rdata1) == 32'd0}, 32'd0);
    check("alu_add", rdata0 + rdata1, 32'd13);

    // Random traffic against the model; small address range forces collisions.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 7));
      wdata  = $urandom;
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      dbg_addr = 5'($urandom_range(0, 7));
      #2;
      check("rnd_rdata0", rdata0, exp_read(raddr0));
      check("rnd_rdata1", rdata1, exp_read(raddr1));
      check("rnd_dbg", dbg_data, model[dbg_addr]);
    end
    @(negedge clk);
    we = 1'b0;

    // Full sweep of stored state through the debug port.
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 check("sweep_dbg", dbg_data, model[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
